fetch: RTL
==========

// Module: fetch
// PURPOSE
//  IF stage of the 5-stage core. Holds the PC, drives the instruction-memory read address and
//  registers the IF/ID bundle (instruction, curr_pc, next_pc) that the decode stage consumes.
//  Honours the hazard/stall/flush controls shared with decode, redirects on EX-stage branches
//  and rti, and runs a two-state RUN/ISR interrupt-entry machine that saves the return PC in epc.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value after reset
//  INT_VECTOR  32'h0000_0100  PC loaded on interrupt entry
//  NOP_INSTR   32'h0000_0013  bubble instruction (addi x0,x0,0) inserted into IF/ID
// PORTS
//  clk            in   1   core clock, all state on posedge
//  rst_n          in   1   reset, asynchronous, active-low
//  hazard         in   1   load-use hazard: hold PC and IF/ID
//  stall_mem      in   1   memory stall: freeze all state
//  flush          in   1   taken branch/jump resolved in EX: redirect to branch_target
//  branch_target  in   32  redirect address, valid with flush
//  rti            in   1   return-from-interrupt resolved in EX: redirect to epc
//  int_req        in   1   level interrupt request from peripherals
//  imem_addr      out  32  instruction-memory address (= pc), combinational read
//  imem_rdata     in   32  instruction word at imem_addr, same cycle
//  instruction    out  32  IF/ID instruction to decode
//  curr_pc        out  32  IF/ID address of instruction
//  next_pc        out  32  IF/ID curr_pc + 4
//  int_ack        out  1   one-cycle pulse on interrupt entry
//  in_isr         out  1   1 while in ISR state
//  epc            out  32  saved return PC
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, instruction=NOP_INSTR, curr_pc=0, next_pc=0,
//   int_ack=0, in_isr=0 (state RUN), epc=RESET_PC, int_pending=0.
//  imem_addr = pc. Addresses wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0). Bits [1:0] of
//   branch_target and epc are forced to 0 when loaded into pc.
//  int_pending: set any cycle int_req=1; cleared only on interrupt entry.
//  Per-cycle priority, highest first:
//   1 stall_mem: pc, IF/ID, epc, state hold; int_pending may still set; int_ack=0.
//   2 rti: pc<=epc; IF/ID<=bubble; state->RUN. (rti outranks flush if both asserted.)
//   3 flush: pc<=branch_target; IF/ID<=bubble.
//   4 entry (int_pending & state RUN): epc<=pc; pc<=INT_VECTOR; IF/ID<=bubble;
//     state->ISR; int_pending<=0; int_ack=1 this cycle. Entry takes priority over hazard:
//     the instruction in IF was never issued, so restarting at epc is exact.
//   5 hazard: pc and IF/ID hold.
//   6 normal: pc<=pc+4; instruction<=imem_rdata; curr_pc<=pc; next_pc<=pc+4.
//  bubble = instruction<=NOP_INSTR, curr_pc<=0, next_pc<=0.
//  hazard together with flush or rti: the redirect wins, because the stalled ID instruction is
//   squashed by decode.
//  State machine: RUN -(entry)-> ISR -(rti)-> RUN. Interrupts are not nested. A request
//   arriving in ISR stays pending and is taken on the first eligible cycle after the rti
//   redirect, which is the cycle following the rti cycle.
//  rti while in RUN: still redirects to epc, and the state stays RUN.
//  int_ack is combinational from the registered state/inputs of the entry condition and is a
//   single-cycle pulse.
//  Latency: fetch-to-decode is 1 cycle; redirect-to-first-new-fetch is 1 cycle
//   (imem_addr = target in the cycle after flush/rti/entry).
// TESTING
//  1 release reset, imem_rdata=32'h0050_0093 @0 -> next cycle instruction=32'h0050_0093,
//    curr_pc=0, next_pc=4, imem_addr=4.
//  2 hazard=1 for 2 cycles at pc=8 -> imem_addr stays 8 and IF/ID is unchanged both cycles;
//    hazard=0 -> pc=12.
//  3 flush=1, hazard=1, branch_target=32'h43 -> imem_addr=32'h40, instruction=32'h13,
//    curr_pc=0.
//  4 int_req pulse at pc=32'h20 -> int_ack=1 (1 cycle), epc=32'h20, imem_addr=32'h100,
//    in_isr=1; 2nd int_req in ISR -> no ack; rti -> imem_addr=32'h20, in_isr=0; next cycle
//    int_ack=1, epc=32'h20.
//  5 stall_mem=1 with flush=1 and int_req=1 -> pc, IF/ID, epc and in_isr unchanged,
//    int_ack=0; stall_mem=0 with flush=1 held -> redirect.
//  6 pc=32'hFFFF_FFFC, normal fetch -> imem_addr=0, next_pc=0; assert rst_n=0 mid-run ->
//    outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch.sv
// IF stage: holds the PC, drives the instruction-memory address and registers the IF/ID bundle.
// Redirects on rti/flush, and enters the interrupt vector from RUN while saving the return PC in epc.
module fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard,
  input  logic        stall_mem,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic        rti,
  input  logic        int_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] curr_pc,
  output logic [31:0] next_pc,
  output logic        int_ack,
  output logic        in_isr,
  output logic [31:0] epc
);

  typedef enum logic {RUN, ISR} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        int_pending;
  logic        entry;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign in_isr    = (state == ISR);

  // Entry yields to stall and to both redirects, but beats hazard: the IF instruction never issued.
  assign entry   = int_pending && (state == RUN) && !stall_mem && !rti && !flush;
  assign int_ack = entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      curr_pc     <= 32'd0;
      next_pc     <= 32'd0;
      epc         <= RESET_PC;
      state       <= RUN;
      int_pending <= 1'b0;
    end else begin
      // A request still asserted in the entry cycle stays pending for after the rti.
      int_pending <= int_req | (int_pending & ~entry);
      if (!stall_mem) begin
        if (rti) begin
          pc          <= {epc[31:2], 2'b00};
          instruction <= NOP_INSTR;
          curr_pc     <= 32'd0;
          next_pc     <= 32'd0;
          state       <= RUN;
        end else if (flush) begin
          pc          <= {branch_target[31:2], 2'b00};
          instruction <= NOP_INSTR;
          curr_pc     <= 32'd0;
          next_pc     <= 32'd0;
        end else if (entry) begin
          epc         <= pc;
          pc          <= INT_VECTOR;
          instruction <= NOP_INSTR;
          curr_pc     <= 32'd0;
          next_pc     <= 32'd0;
          state       <= ISR;
        end else if (!hazard) begin
          pc          <= pc_plus4;
          instruction <= imem_rdata;
          curr_pc     <= pc;
          next_pc     <= pc_plus4;
        end
      end
    end
  end

endmodule
